// File: rtl/inst_mem_loadable_if.sv
// Load-port and fetch-port bundle for inst_mem_loadable.
// Optional parity signals exist only when INST_MEM_PARITY_EN is defined.
interface inst_mem_loadable_if #(
  parameter int unsigned A = 10,
  parameter int unsigned W = 9
);
  logic         LoadStart;
  logic         LoadValid;
  logic [W-1:0] LoadData;
  logic         LoadLast;
  logic         LoadReady;
  logic         LoadDone;
  logic [A:0]   LoadCount;
  logic         Busy;
  logic         FetchReq;
  logic [A-1:0] FetchAddr;
  logic         FetchValid;
  logic [W-1:0] InstOut;
`ifdef INST_MEM_PARITY_EN
  logic         FetchErr;
  logic         InjectErr;
`endif

  modport slave (
`ifdef INST_MEM_PARITY_EN
    input  InjectErr,
    output FetchErr,
`endif
    input  LoadStart, LoadValid, LoadData, LoadLast, FetchReq, FetchAddr,
    output LoadReady, LoadDone, LoadCount, Busy, FetchValid, InstOut
  );

  modport master (
`ifdef INST_MEM_PARITY_EN
    output InjectErr,
    input  FetchErr,
`endif
    output LoadStart, LoadValid, LoadData, LoadLast, FetchReq, FetchAddr,
    input  LoadReady, LoadDone, LoadCount, Busy, FetchValid, InstOut
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: streamed program load, one-cycle registered fetch,
// halt word beyond the loaded program. Optional parity via INST_MEM_PARITY_EN.
module inst_mem_loadable #(
  parameter int unsigned A = 10,
  parameter int unsigned W = 9
) (
  input logic               Clk,
  input logic               Reset_n,
  inst_mem_loadable_if.slave bus
);
  localparam int unsigned DEPTH = 1 << A;
`ifdef INST_MEM_PARITY_EN
  localparam int unsigned MW = W + 1;
`else
  localparam int unsigned MW = W;
`endif

  typedef enum logic [1:0] {EMPTY, LOADING, RUN} state_t;

  state_t        r_state;
  logic [MW-1:0] r_mem [DEPTH];
  logic [A:0]    r_count;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_fvalid;
  logic [W-1:0]  r_inst;

  logic          w_accept;
  logic          w_end;
  logic          w_serve;
  logic          w_in_range;
  logic [MW-1:0] w_rd;
  logic [MW-1:0] w_wr_word;

  assign w_accept   = r_ready && bus.LoadValid;
  // Last word either flagged by the source or filling the final slot
  assign w_end      = w_accept && (bus.LoadLast || (r_count == (A+1)'(DEPTH - 1)));
  assign w_serve    = (r_state == RUN) && bus.FetchReq;
  assign w_in_range = {1'b0, bus.FetchAddr} < r_count;
  assign w_rd       = r_mem[bus.FetchAddr];

`ifdef INST_MEM_PARITY_EN
  logic r_ferr;
  assign w_wr_word    = {(^bus.LoadData) ^ bus.InjectErr, bus.LoadData};
  assign bus.FetchErr = r_ferr;

  // Parity flag tracks FetchValid; halt returns never flag an error
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_ferr <= 1'b0;
    else          r_ferr <= w_serve && w_in_range && ((^w_rd[W-1:0]) != w_rd[W]);
  end
`else
  assign w_wr_word = bus.LoadData;
`endif

  // Storage has no reset; stale words are masked by r_count
  always_ff @(posedge Clk) begin
    if (w_accept) r_mem[r_count[A-1:0]] <= w_wr_word;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= EMPTY;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fvalid <= 1'b0;
      r_inst   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_fvalid <= w_serve;
      if (w_serve) r_inst <= w_in_range ? w_rd[W-1:0] : '1;
      case (r_state)
        EMPTY: begin
          if (bus.LoadStart) begin
            r_state <= LOADING;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_count <= '0;
          end
        end
        LOADING: begin
          if (w_accept) r_count <= r_count + (A+1)'(1);
          if (w_end) begin
            r_state <= RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        RUN: begin
          if (bus.LoadStart) begin
            r_state <= LOADING;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_count <= '0;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.LoadReady  = r_ready;
  assign bus.LoadDone   = r_done;
  assign bus.LoadCount  = r_count;
  assign bus.Busy       = r_busy;
  assign bus.FetchValid = r_fvalid;
  assign bus.InstOut    = r_inst;
endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench for inst_mem_loadable (A=4, W=9): fetch expectations are queued
// by the driver and popped by a monitor whenever FetchValid is seen.
module tb_inst_mem_loadable;
  localparam int unsigned A = 4;
  localparam int unsigned W = 9;

  logic Clk;
  logic Reset_n;
  int   n_vec;
  int   n_err;
  logic [W:0] exp_q[$];

  inst_mem_loadable_if #(.A(A), .W(W)) bus ();
  inst_mem_loadable #(.A(A), .W(W)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_session();
    bus.LoadStart = 1'b1;
    step();
    bus.LoadStart = 1'b0;
    check("busy_after_start", 32'(bus.Busy), 32'd1);
    check("ready_after_start", 32'(bus.LoadReady), 32'd1);
  endtask

  task automatic put_word(input logic [W-1:0] d, input logic last, input logic inj);
    bus.LoadValid = 1'b1;
    bus.LoadData  = d;
    bus.LoadLast  = last;
`ifdef INST_MEM_PARITY_EN
    bus.InjectErr = inj;
`else
    if (inj) $display("note: InjectErr requested without parity build");
`endif
    step();
    bus.LoadValid = 1'b0;
    bus.LoadLast  = 1'b0;
`ifdef INST_MEM_PARITY_EN
    bus.InjectErr = 1'b0;
`endif
  endtask

  task automatic fetch(input logic [A-1:0] a, input logic [W-1:0] exp, input logic err);
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = a;
    exp_q.push_back({err, exp});
    step();
    bus.FetchReq = 1'b0;
  endtask

  task automatic check_done_pulse(input int cnt);
    check("done_pulse", 32'(bus.LoadDone), 32'd1);
    check("busy_end", 32'(bus.Busy), 32'd0);
    check("ready_end", 32'(bus.LoadReady), 32'd0);
    check("count_end", 32'(bus.LoadCount), 32'(cnt));
    step();
    check("done_one_cycle", 32'(bus.LoadDone), 32'd0);
  endtask

  // Monitor: every FetchValid must match the oldest queued expectation
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge Clk);
      if (bus.FetchValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_fetch_valid: got InstOut %0h, expected no result", bus.InstOut);
        end else begin
          e = exp_q.pop_front();
          check("fetch_data", 32'(bus.InstOut), 32'(e[W-1:0]));
`ifdef INST_MEM_PARITY_EN
          check("fetch_err", 32'(bus.FetchErr), 32'(e[W]));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset_n       = 1'b0;
    bus.LoadStart = 1'b0;
    bus.LoadValid = 1'b0;
    bus.LoadData  = '0;
    bus.LoadLast  = 1'b0;
    bus.FetchReq  = 1'b0;
    bus.FetchAddr = '0;
`ifdef INST_MEM_PARITY_EN
    bus.InjectErr = 1'b0;
`endif
    repeat (3) step();
    check("rst_ready", 32'(bus.LoadReady), 32'd0);
    check("rst_done", 32'(bus.LoadDone), 32'd0);
    check("rst_count", 32'(bus.LoadCount), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_fvalid", 32'(bus.FetchValid), 32'd0);
    check("rst_inst", 32'(bus.InstOut), 32'd0);
    Reset_n = 1'b1;
    step();

    // Fetch while EMPTY is ignored
    bus.FetchReq = 1'b1;
    bus.FetchAddr = '0;
    step();
    bus.FetchReq = 1'b0;
    check("empty_fvalid", 32'(bus.FetchValid), 32'd0);
    check("empty_inst", 32'(bus.InstOut), 32'd0);

    // Three-word program with LoadLast
    start_session();
    put_word(9'h0A1, 1'b0, 1'b0);
    put_word(9'h1F0, 1'b0, 1'b0);
    put_word(9'h003, 1'b1, 1'b0);
    check_done_pulse(3);
    fetch(4'd0, 9'h0A1, 1'b0);
    fetch(4'd1, 9'h1F0, 1'b0);
    fetch(4'd2, 9'h003, 1'b0);
    fetch(4'd3, 9'h1FF, 1'b0);
    step();
    step();
    check("idle_fvalid", 32'(bus.FetchValid), 32'd0);
    check("inst_hold", 32'(bus.InstOut), 32'h1FF);

    // Full memory ends the session without LoadLast
    start_session();
    for (int i = 0; i < 16; i++) put_word(W'(i), 1'b0, 1'b0);
    check("done_full", 32'(bus.LoadDone), 32'd1);
    check("count_full", 32'(bus.LoadCount), 32'd16);
    bus.LoadValid = 1'b1;
    bus.LoadData  = 9'h1AB;
    check("ready_17th", 32'(bus.LoadReady), 32'd0);
    step();
    bus.LoadValid = 1'b0;
    check("count_after_17th", 32'(bus.LoadCount), 32'd16);
    check("done_cleared_full", 32'(bus.LoadDone), 32'd0);
    fetch(4'd15, 9'h00F, 1'b0);
    fetch(4'd1, 9'h001, 1'b0);

    // Fetch and LoadStart together: fetch sees old contents and count
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 4'd2;
    bus.LoadStart = 1'b1;
    exp_q.push_back({1'b0, 9'h002});
    step();
    bus.FetchReq  = 1'b0;
    bus.LoadStart = 1'b0;
    check("restart_busy", 32'(bus.Busy), 32'd1);
    check("restart_count", 32'(bus.LoadCount), 32'd0);
    put_word(9'h055, 1'b0, 1'b0);
    check("gap_count_a", 32'(bus.LoadCount), 32'd1);
    bus.LoadStart = 1'b1;
    step();
    bus.LoadStart = 1'b0;
    step();
    check("gap_count_b", 32'(bus.LoadCount), 32'd1);
    check("gap_busy", 32'(bus.Busy), 32'd1);
    check("gap_ready", 32'(bus.LoadReady), 32'd1);
    put_word(9'h0AA, 1'b1, 1'b0);
    check_done_pulse(2);
    fetch(4'd0, 9'h055, 1'b0);
    fetch(4'd1, 9'h0AA, 1'b0);
    fetch(4'd2, 9'h1FF, 1'b0);

    // Asynchronous reset in the middle of a load
    start_session();
    put_word(9'h111, 1'b0, 1'b0);
    put_word(9'h122, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check("mid_rst_ready", 32'(bus.LoadReady), 32'd0);
    check("mid_rst_count", 32'(bus.LoadCount), 32'd0);
    check("mid_rst_inst", 32'(bus.InstOut), 32'd0);
    check("mid_rst_fvalid", 32'(bus.FetchValid), 32'd0);
    step();
    Reset_n = 1'b1;
    step();
    start_session();
    put_word(9'h111, 1'b0, 1'b0);
    put_word(9'h122, 1'b0, 1'b0);
    put_word(9'h133, 1'b0, 1'b0);
    put_word(9'h144, 1'b0, 1'b0);
    put_word(9'h155, 1'b1, 1'b0);
    check_done_pulse(5);
    fetch(4'd4, 9'h155, 1'b0);
    fetch(4'd0, 9'h111, 1'b0);
    fetch(4'd5, 9'h1FF, 1'b0);

`ifdef INST_MEM_PARITY_EN
    start_session();
    put_word(9'h001, 1'b0, 1'b1);
    put_word(9'h002, 1'b1, 1'b0);
    check_done_pulse(2);
    fetch(4'd0, 9'h001, 1'b1);
    fetch(4'd1, 9'h002, 1'b0);
    fetch(4'd7, 9'h1FF, 1'b0);
`endif

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Loadable instruction memory that replaces the fixed, file-initialised instruction ROM. It sits between the program counter / fetch stage and an external program-load port. Programs stream in over a valid/ready interface after reset, with no simulator file preload. Fetch is a registered, one-cycle-latency request/valid read. Addresses beyond the loaded program return the all-ones halt word.

## Interface
Parameters:
- A, 10, address width; depth is 2**A words
- W, 9, instruction width in bits

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- LoadStart  in  1  begin a load session; write pointer returns to 0
- LoadValid  in  1  LoadData is valid this cycle
- LoadData  in  W  instruction word to store
- LoadLast  in  1  qualifies the final word of the session
- LoadReady  out  1  block accepts a load word this cycle
- LoadDone  out  1  one-cycle pulse when a session completes
- LoadCount  out  A+1  number of words written in the last or current session
- Busy  out  1  high while a load session is active
- FetchReq  in  1  fetch request
- FetchAddr  in  A  fetch address, sampled with FetchReq
- FetchValid  out  1  InstOut is valid this cycle
- InstOut  out  W  fetched instruction
- FetchErr  out  1  parity error on this fetch (INST_MEM_PARITY_EN only)
- InjectErr  in  1  invert stored parity bit on the accepted write (INST_MEM_PARITY_EN only)

## Operation
- States: EMPTY, LOADING and RUN. Reset enters EMPTY.
- EMPTY:
  - LoadStart moves to LOADING.
  - FetchReq is ignored; FetchValid stays 0.
- LOADING:
  - Busy=1 and LoadReady=1.
  - A word is accepted when LoadValid&&LoadReady. It is written to mem[ptr], then ptr and LoadCount increment.
  - The session ends on an accepted word with LoadLast=1, or when the 2**A-th word is accepted (full).
  - LoadStart is ignored in this state, and FetchReq is ignored.
- Session end: state becomes RUN and LoadDone pulses for exactly one cycle.
- RUN:
  - FetchReq is served.
  - LoadStart restarts a session: state goes to LOADING, ptr=0, LoadCount=0. Memory is not cleared.
- Fetch result:
  - If FetchAddr < LoadCount, InstOut = mem[FetchAddr].
  - Otherwise InstOut = all ones (halt).
- Memory array is not reset. Only the control registers and outputs are reset.
- LoadCount saturates at 2**A, which is why it is A+1 bits wide.

## Timing
- Reset values: LoadReady=0, LoadDone=0, LoadCount=0, Busy=0, FetchValid=0, InstOut=0, FetchErr=0.
- LoadStart sampled at edge k gives Busy=1 and LoadReady=1 after edge k.
- Final word accepted at edge k gives:
  - LoadReady=0, Busy=0 and LoadDone=1 after edge k;
  - LoadDone=0 after edge k+1;
  - fetch allowed from edge k+1.
- Fetch latency is one cycle: FetchReq and FetchAddr sampled at edge k give FetchValid=1 and InstOut after edge k.
- Back-to-back FetchReq sustains one result per cycle.
- InstOut holds its last value while FetchValid=0.
- Simultaneous FetchReq and LoadStart in RUN: the fetch is served with the old contents and old LoadCount, and the state goes to LOADING.
- Reset_n asserted mid-load: all outputs return immediately to their reset values and the state becomes EMPTY. The partially written words remain but are unreachable because LoadCount=0.

## Configuration
- INST_MEM_PARITY_EN:
  - Defined: each word stores W+1 bits, the extra bit being even parity of LoadData computed at write. InjectErr=1 on an accepted write inverts that stored parity bit.
  - On a fetch with FetchAddr < LoadCount, FetchErr = recomputed parity != stored parity. FetchErr is valid alongside FetchValid and is 0 otherwise, including halt returns.
  - Not defined: W-bit storage; the FetchErr and InjectErr ports do not exist.

## Test plan
- Reset, then FetchReq with FetchAddr=0: FetchValid stays 0 and InstOut=0.
- A=4, W=9: load 3'h words 9'h0A1, 9'h1F0, 9'h003, with LoadLast on the third. Expect LoadDone for one cycle and LoadCount=3. Fetches of addresses 0, 1, 2 return 9'h0A1, 9'h1F0, 9'h003, each one cycle after the request. A fetch of address 3 returns 9'h1FF.
- A=4: load 16 words 9'h000..9'h00F with LoadLast=0 throughout. The session ends on the 16th word and LoadCount=16. A 17th LoadValid sees LoadReady=0. Fetching address 15 returns 9'h00F.
- Deassert LoadValid for 2 cycles mid-session and toggle LoadStart meanwhile. No word is written, ptr is unchanged, and the session continues.
- Assert Reset_n=0 after 2 of 5 words. Outputs go to reset values asynchronously and the state is EMPTY. A new 5-word load completes correctly.
- INST_MEM_PARITY_EN: load 9'h001 with InjectErr=1 and 9'h002 with InjectErr=0. Fetch 0 gives FetchErr=1; fetch 1 gives FetchErr=0.
